// File: rtl/dividend_reconstruct_pkg.sv
// Shared definitions for the dividend reconstruction block: default width and FSM states.
package dividend_reconstruct_pkg;

  localparam int unsigned DR_WIDTH = 4;

  typedef enum logic [2:0] {
    S_LOAD      = 3'd0,
    S_LOAD_WAIT = 3'd1,
    S_INIT      = 3'd2,
    S_STEP      = 3'd3,
    S_DONE      = 3'd4
  } state_t;

endpackage

// File: rtl/dividend_reconstruct_datapath.sv
// Shift-and-add datapath: operand capture, multiply accumulate of quotient*divisor on top
// of the remainder, and the result/validity registers.
module dividend_reconstruct_datapath
  import dividend_reconstruct_pkg::*;
#(
  parameter int unsigned WIDTH = DR_WIDTH
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   ld_data,
  input  logic                   init,
  input  logic                   step,
  input  logic                   ld_r,
  input  logic [3*WIDTH-1:0]     data_in,
  output logic                   step_last,
  output logic [2*WIDTH-1:0]     data_result,
  output logic                   rem_invalid
);

  localparam int unsigned RW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] div_r;
  logic [WIDTH-1:0] rem_r;
  logic [RW-1:0]    acc;
  logic [RW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] count;

  // The step in flight is the last one once count reaches WIDTH-1.
  assign step_last = (count == CNT_W'(WIDTH - 1));

  // Operand capture, then one conditional add and shift per step; results latched at the end.
  always_ff @(posedge clk) begin
    if (resetn) begin
      quot_r      <= '0;
      div_r       <= '0;
      rem_r       <= '0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      count       <= '0;
      data_result <= '0;
      rem_invalid <= 1'b0;
    end else begin
      if (ld_data) begin
        quot_r <= data_in[WIDTH-1:0];
        div_r  <= data_in[2*WIDTH-1:WIDTH];
        rem_r  <= data_in[3*WIDTH-1:2*WIDTH];
      end
      if (init) begin
        acc    <= RW'(rem_r);
        mcand  <= RW'(div_r);
        mplier <= quot_r;
        count  <= '0;
      end else if (step) begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + CNT_W'(1);
      end
      if (ld_r) begin
        data_result <= acc;
        rem_invalid <= (rem_r >= div_r);
      end
    end
  end

endmodule

// File: rtl/dividend_reconstruct.sv
// Rebuilds dividend = quotient*divisor + remainder using a go press/release handshake;
// control FSM here, arithmetic in dividend_reconstruct_datapath.
module dividend_reconstruct
  import dividend_reconstruct_pkg::*;
#(
  parameter int unsigned WIDTH = DR_WIDTH
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 go,
  input  logic [3*WIDTH-1:0]   data_in,
  output logic [2*WIDTH-1:0]   data_result,
  output logic                 done,
  output logic                 busy,
  output logic                 rem_invalid
);

  state_t state;
  logic   ld_data;
  logic   init;
  logic   step;
  logic   ld_r;
  logic   step_last;

  // Datapath controls decode directly from the current state.
  assign ld_data = (state == S_LOAD);
  assign init    = (state == S_INIT);
  assign step    = (state == S_STEP);
  assign ld_r    = (state == S_DONE);

  // Control FSM; busy is registered to track exactly the S_INIT/S_STEP residency.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state <= S_LOAD;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_LOAD: begin
          busy <= 1'b0;
          if (go) begin
            state <= S_LOAD_WAIT;
          end
        end
        S_LOAD_WAIT: begin
          if (!go) begin
            state <= S_INIT;
            busy  <= 1'b1;
          end
        end
        S_INIT: begin
          state <= S_STEP;
          busy  <= 1'b1;
        end
        S_STEP: begin
          if (step_last) begin
            state <= S_DONE;
            busy  <= 1'b0;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_LOAD;
        end
        default: begin
          state <= S_LOAD;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  dividend_reconstruct_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk         (clk),
    .resetn      (resetn),
    .ld_data     (ld_data),
    .init        (init),
    .step        (step),
    .ld_r        (ld_r),
    .data_in     (data_in),
    .step_last   (step_last),
    .data_result (data_result),
    .rem_invalid (rem_invalid)
  );

endmodule

// File: tb/tb_dividend_reconstruct.sv
// Directed bench for dividend_reconstruct (WIDTH=4): vector table plus corner sequences.
module tb_dividend_reconstruct;

  localparam int unsigned W = 4;

  logic           clk;
  logic           resetn;
  logic           go;
  logic [3*W-1:0] data_in;
  logic [2*W-1:0] data_result;
  logic           done;
  logic           busy;
  logic           rem_invalid;

  int tests;
  int errors;
  int last_result;

  typedef struct {
    int q;
    int d;
    int r;
    int exp_res;
    int exp_inv;
  } vec_t;

  vec_t vecs[6];

  dividend_reconstruct #(.WIDTH(W)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .go          (go),
    .data_in     (data_in),
    .data_result (data_result),
    .done        (done),
    .busy        (busy),
    .rem_invalid (rem_invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3*W-1:0] pack(input int q, input int d, input int r);
    return {W'(r), W'(d), W'(q)};
  endfunction

  // Press/release go, measure latency after the release edge, check result and done pulse.
  task automatic run_op(input int q, input int d, input int r, input int exp_res, input int exp_inv);
    int n;
    @(negedge clk);
    data_in = pack(q, d, r);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done) break;
      check("hold_result", int'(data_result), last_result);
    end
    check("done_seen", int'(done), 1);
    check("latency", n - 1, W + 2);
    check("result", int'(data_result), exp_res);
    check("rem_invalid", int'(rem_invalid), exp_inv);
    @(negedge clk);
    check("done_drop", int'(done), 0);
    last_result = exp_res;
  endtask

  initial begin
    int pulses;
    int cap_res;
    int cap_inv;

    tests = 0;
    errors = 0;
    last_result = 0;
    go = 1'b0;
    data_in = '0;
    resetn = 1'b1;

    vecs[0] = '{q: 3,  d: 5,  r: 2,  exp_res: 'h11, exp_inv: 0};
    vecs[1] = '{q: 15, d: 15, r: 14, exp_res: 'hEF, exp_inv: 0};
    vecs[2] = '{q: 0,  d: 0,  r: 0,  exp_res: 'h00, exp_inv: 1};
    vecs[3] = '{q: 2,  d: 3,  r: 3,  exp_res: 'h09, exp_inv: 1};
    vecs[4] = '{q: 4,  d: 4,  r: 0,  exp_res: 'h10, exp_inv: 0};
    vecs[5] = '{q: 1,  d: 9,  r: 8,  exp_res: 'h11, exp_inv: 0};

    repeat (2) @(negedge clk);
    resetn = 1'b0;
    check("rst_result", int'(data_result), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_inv", int'(rem_invalid), 0);

    // Table: includes back-to-back ops where the previous result must hold until done.
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].q, vecs[i].d, vecs[i].r, vecs[i].exp_res, vecs[i].exp_inv);
    end

    // go held high: no start until release; mid-op go/data_in activity is ignored.
    @(negedge clk);
    data_in = pack(3, 5, 2);
    go = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("busy_while_held", int'(busy), 0);
    end
    go = 1'b0;
    @(negedge clk);
    check("busy_after_release", int'(busy), 1);
    @(negedge clk);
    @(negedge clk);
    check("busy_in_step", int'(busy), 1);
    go = 1'b1;
    data_in = pack(15, 15, 15);
    @(negedge clk);
    go = 1'b0;
    pulses = 0;
    cap_res = -1;
    cap_inv = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        cap_res = int'(data_result);
        cap_inv = int'(rem_invalid);
      end
    end
    check("single_done", pulses, 1);
    check("ignore_result", cap_res, 'h11);
    check("ignore_inv", cap_inv, 0);
    last_result = 'h11;

    // Reset mid S_STEP clears everything, then a fresh op completes normally.
    @(negedge clk);
    data_in = pack(3, 5, 2);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_result", int'(data_result), 0);
    check("midrst_inv", int'(rem_invalid), 0);
    resetn = 1'b0;
    last_result = 0;
    run_op(7, 2, 1, 'h0F, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
